mem_port_arbiter: RTL

Arbitrates the single byte-wide processor memory between the instruction-fetch requester (up to 10 bytes per instruction) and the data-memory requester (8-byte quadword read/write). It serialises each request into one byte per cycle and assembles read data little-endian. It sits between the fetch/memory stages and the 4 KiB byte array. It also reports out-of-range accesses, which feed the `imem_error`/`dmem_error` status.

---
 rtl/y86_mem_pkg.sv | 8 +
 rtl/mem_range_check.sv | 22 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg: shared sizes, FSM states and requester ids for the memory port arbiter.
package y86_mem_pkg;
  localparam int MEM_SIZE = 4096;
  localparam int IF_MAX_LEN = 10;
  localparam int DM_LEN = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} arb_state_t;
  typedef enum logic {REQ_IF, REQ_DM} arb_req_t;
endpackage

// File: rtl/mem_range_check.sv
// mem_range_check: flags zero/overlong lengths, 64-bit wrap and out-of-array accesses.
// Build option DM_ALIGN_CHECK_EN also rejects data accesses not on a quadword boundary.
module mem_range_check #(
  parameter int MEM_SIZE = 4096
) (
  input  logic [63:0] addr,
  input  logic [3:0]  len,
  input  logic        is_dm,
  output logic        err
);
  import y86_mem_pkg::*;
  logic [64:0] last;
  logic        mis;
  // 65-bit end address so a wrap past 2^64 lands above MEM_SIZE
  assign last = {1'b0, addr} + {61'b0, len} - 65'd1;
`ifdef DM_ALIGN_CHECK_EN
  assign mis = is_dm && addr[2:0] != 3'd0;
`else
  assign mis = 1'b0;
`endif
  assign err = len == 4'd0 || (!is_dm && len > 4'(IF_MAX_LEN)) || last >= 65'(MEM_SIZE) || mis;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide memory between fetch and data ports, one byte per cycle.
// Optional DM_ALIGN_CHECK_EN makes unaligned data accesses an error.
module mem_port_arbiter #(
  parameter int MEM_SIZE = 4096,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [63:0]   if_addr,
  input  logic [3:0]    if_len,
  output logic [79:0]   if_rdata,
  output logic          if_done,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [63:0]   dm_addr,
  input  logic [63:0]   dm_wdata,
  output logic [63:0]   dm_rdata,
  output logic          dm_done,
  output logic          dm_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);
  import y86_mem_pkg::*;
  arb_state_t    state_q, state_d;
  arb_req_t      last_q, last_d, gnt_q, gnt_d, sel;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    len_q, len_d, k_q, k_d, g_len;
  logic          we_q, we_d, err_q, err_d, g_err;
  logic [63:0]   wdata_q, wdata_d, dmr_q, dmr_d, g_addr;
  logic [79:0]   ifr_q, ifr_d;
  // ties go to whoever was not served last
  assign sel = (if_req && dm_req) ? (last_q == REQ_IF ? REQ_DM : REQ_IF) : (dm_req ? REQ_DM : REQ_IF);
  assign g_addr = sel == REQ_DM ? dm_addr : if_addr;
  assign g_len = sel == REQ_DM ? 4'(DM_LEN) : if_len;
  mem_range_check #(.MEM_SIZE(MEM_SIZE)) u_chk (
    .addr  (g_addr),
    .len   (g_len),
    .is_dm (sel == REQ_DM),
    .err   (g_err)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gnt_d = gnt_q;
    addr_d = addr_q;
    len_d = len_q;
    we_d = we_q;
    wdata_d = wdata_q;
    k_d = k_q;
    err_d = err_q;
    ifr_d = ifr_q;
    dmr_d = dmr_q;
    mem_addr = '0;
    mem_we = 1'b0;
    mem_wdata = 8'd0;
    case (state_q)
      ST_IDLE: if (if_req || dm_req) begin
        gnt_d = sel;
        addr_d = g_addr[AW-1:0];
        len_d = g_len;
        we_d = dm_we && sel == REQ_DM;
        wdata_d = dm_wdata;
        k_d = 4'd0;
        err_d = g_err;
        state_d = g_err ? ST_DONE : ST_XFER;
        if (sel == REQ_DM) dmr_d = '0;
        else ifr_d = '0;
      end
      ST_XFER: begin
        mem_addr = addr_q + AW'(k_q);
        mem_we = we_q;
        mem_wdata = we_q ? wdata_q[{k_q[2:0], 3'b000} +: 8] : 8'd0;
        if (!we_q && gnt_q == REQ_IF) ifr_d[{k_q, 3'b000} +: 8] = mem_rdata;
        if (!we_q && gnt_q == REQ_DM) dmr_d[{k_q[2:0], 3'b000} +: 8] = mem_rdata;
        k_d = k_q + 4'd1;
        state_d = k_q == len_q - 4'd1 ? ST_DONE : ST_XFER;
      end
      ST_DONE: begin
        last_d = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q <= REQ_IF;
      gnt_q <= REQ_IF;
      addr_q <= '0;
      len_q <= 4'd0;
      we_q <= 1'b0;
      wdata_q <= 64'd0;
      k_q <= 4'd0;
      err_q <= 1'b0;
      ifr_q <= 80'd0;
      dmr_q <= 64'd0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      addr_q <= addr_d;
      len_q <= len_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      k_q <= k_d;
      err_q <= err_d;
      ifr_q <= ifr_d;
      dmr_q <= dmr_d;
    end
  end
  assign if_done = state_q == ST_DONE && gnt_q == REQ_IF;
  assign dm_done = state_q == ST_DONE && gnt_q == REQ_DM;
  assign if_err = if_done && err_q;
  assign dm_err = dm_done && err_q;
  assign if_rdata = ifr_q;
  assign dm_rdata = dmr_q;
endmodule
